// File: rtl/command_reader_pkg.sv
// Shared opcodes, reply bytes and state encoding for the UART command interpreter.
// The state values double as the state_debug output encoding.
package command_reader_pkg;

  localparam logic [3:0] OP_SET_THRESHOLD = 4'h1;
  localparam logic [3:0] OP_SET_FREQUENCY = 4'h2;
  localparam logic [3:0] OP_READ_MAX      = 4'h3;
  localparam logic [3:0] OP_ARM           = 4'h4;
  localparam logic [3:0] OP_PING          = 4'h5;

  localparam logic [7:0] REPLY_ACK  = 8'h06;
  localparam logic [7:0] REPLY_NAK  = 8'h15;
  localparam logic [7:0] REPLY_ARM  = 8'hA5;
  localparam logic [7:0] REPLY_PING = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DECODE    = 4'd1,
    ST_GET_ARG   = 4'd2,
    ST_WAIT_FFT  = 4'd3,
    ST_WAIT_TRIG = 4'd4,
    ST_WRITE     = 4'd5,
    ST_SEND      = 4'd6,
    ST_TX_GAP    = 4'd7
  } state_t;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Counts tick strobes while a wait state is active; expired flags the tick
// that completes TIMEOUT_TICKS so the caller can abort in that same cycle.
module cmd_timeout_timer #(
  parameter  int TIMEOUT_TICKS = 1000,
  localparam int CW            = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_b || clear) begin
      count <= '0;
    end else if (tick && (count != CW'(TIMEOUT_TICKS))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = !clear && tick && (count == CW'(TIMEOUT_TICKS - 1));

endmodule

// File: rtl/command_reader_mc.sv
// Multi-channel UART command interpreter: decodes opcode+channel bytes, issues
// per-channel parameter writes and serialises replies (ACK/NAK, peaks, trigger ack).
module command_reader_mc
  import command_reader_pkg::*;
#(
  parameter  int N_CH          = 4,
  parameter  int MAX_W         = 10,
  parameter  int TIMEOUT_TICKS = 1000,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int NB            = (MAX_W + 7) / 8
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   tick,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   tx_ready,
  input  logic                   trigger,
  input  logic                   fft_data_ready,
  input  logic [N_CH*MAX_W-1:0]  max_value,
  output logic [CH_W-1:0]        channel_sel,
  output logic [7:0]             param_data,
  output logic                   threshold_we,
  output logic                   frequency_we,
  output logic [7:0]             tx_data,
  output logic                   tx_write_en,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun,
  output logic [3:0]             state_debug
);

  localparam int RW = NB * 8;

  state_t          state, state_d;
  logic [7:0]      cmd_byte, cmd_d;
  logic [CH_W-1:0] chan_d;
  logic [7:0]      param_d, txd_d;
  logic            thr_d, freq_d, twe_d, terr_d, ovr_d, busy_d;
  logic [RW-1:0]   shift_reg, shift_d, peak_ext;
  logic [2:0]      bytes_left, left_d;
  logic [MAX_W-1:0] sel_peak;
  logic            chan_ok, in_wait, expired;

  assign in_wait = (state == ST_GET_ARG) || (state == ST_WAIT_FFT) || (state == ST_WAIT_TRIG);
  assign chan_ok = ({1'b0, cmd_byte[3:0]} < 5'(N_CH));
  assign state_debug = state;

  cmd_timeout_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .clear   (!in_wait),
    .tick    (tick),
    .expired (expired)
  );

  always_comb begin
    sel_peak = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (channel_sel == CH_W'(c)) sel_peak = max_value[c*MAX_W +: MAX_W];
    end
  end

  assign peak_ext = RW'(sel_peak);

  always_comb begin
    state_d = state;
    cmd_d   = cmd_byte;
    chan_d  = channel_sel;
    param_d = param_data;
    txd_d   = tx_data;
    shift_d = shift_reg;
    left_d  = bytes_left;
    thr_d   = 1'b0;
    freq_d  = 1'b0;
    terr_d  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        left_d = 3'd0;
        if (!chan_ok) begin
          txd_d   = REPLY_NAK;
          state_d = ST_SEND;
        end else begin
          chan_d = CH_W'(cmd_byte[3:0]);
          case (cmd_byte[7:4])
            OP_SET_THRESHOLD, OP_SET_FREQUENCY: state_d = ST_GET_ARG;
            OP_READ_MAX: state_d = ST_WAIT_FFT;
            OP_ARM:      state_d = ST_WAIT_TRIG;
            OP_PING: begin
              txd_d   = REPLY_PING;
              state_d = ST_SEND;
            end
            default: begin
              txd_d   = REPLY_NAK;
              state_d = ST_SEND;
            end
          endcase
        end
      end
      ST_GET_ARG: begin
        if (rx_valid) begin
          param_d = rx_data;
          thr_d   = (cmd_byte[7:4] == OP_SET_THRESHOLD);
          freq_d  = (cmd_byte[7:4] == OP_SET_FREQUENCY);
          state_d = ST_WRITE;
        end else if (expired) begin
          txd_d   = REPLY_NAK;
          terr_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_WRITE: begin
        txd_d   = REPLY_ACK;
        state_d = ST_SEND;
      end
      ST_WAIT_FFT: begin
        // Snapshot the whole zero-extended peak so later bus changes cannot tear the reply
        if (fft_data_ready) begin
          txd_d   = peak_ext[RW-1 -: 8];
          shift_d = peak_ext << 8;
          left_d  = 3'(NB - 1);
          state_d = ST_SEND;
        end else if (expired) begin
          txd_d   = REPLY_NAK;
          terr_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_WAIT_TRIG: begin
        if (trigger) begin
          txd_d   = REPLY_ARM;
          state_d = ST_SEND;
        end else if (expired) begin
          txd_d   = REPLY_NAK;
          terr_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_write_en) state_d = ST_TX_GAP;
      end
      ST_TX_GAP: begin
        if (bytes_left != 3'd0) begin
          txd_d   = shift_reg[RW-1 -: 8];
          shift_d = shift_reg << 8;
          left_d  = bytes_left - 3'd1;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The strobe is a registered look-ahead; tx_ready seen during TX_GAP never counts
    twe_d  = (state_d == ST_SEND) && (state != ST_TX_GAP) && tx_ready;
    ovr_d  = rx_valid && (state != ST_IDLE) && (state != ST_GET_ARG);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state        <= ST_IDLE;
      cmd_byte     <= '0;
      channel_sel  <= '0;
      param_data   <= '0;
      tx_data      <= '0;
      shift_reg    <= '0;
      bytes_left   <= '0;
      threshold_we <= 1'b0;
      frequency_we <= 1'b0;
      tx_write_en  <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cmd_byte     <= cmd_d;
      channel_sel  <= chan_d;
      param_data   <= param_d;
      tx_data      <= txd_d;
      shift_reg    <= shift_d;
      bytes_left   <= left_d;
      threshold_we <= thr_d;
      frequency_we <= freq_d;
      tx_write_en  <= twe_d;
      timeout_err  <= terr_d;
      overrun      <= ovr_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: doc/command_reader_mc.md
# command_reader_mc

Parametrised multi-channel UART command interpreter for the acoustics front end. It sits between the UART receiver/transmitter and the per-channel FFT/threshold logic. It decodes opcode+channel command bytes, collects argument bytes, and issues per-channel threshold/frequency writes. It also returns multi-byte peak values or trigger acknowledgements, with tick-based timeouts on every wait state.

## Interface
- N_CH, 4: number of hydrophone channels; 1..16
- MAX_W, 10: width of each channel's peak value; 1..32
- TIMEOUT_TICKS, 1000: `tick` pulses allowed in any wait state before abort; ≥1
- Derived: CH_W = max(1,$clog2(N_CH)); NB = ceil(MAX_W/8) reply bytes
- clk  in  1  system clock
- reset_b  in  1  synchronous, active-low reset
- tick  in  1  one-cycle timer strobe (slow time base, already in clk domain)
- rx_data  in  8  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle pulse per received byte
- tx_ready  in  1  transmitter idle, can accept a byte
- trigger  in  1  level; acoustic trigger detected
- fft_data_ready  in  1  level; max_value bus is valid
- max_value  in  N_CH*MAX_W  packed peaks, channel c at [c*MAX_W +: MAX_W]
- channel_sel  out  CH_W  channel of the last accepted command
- param_data  out  8  argument byte for threshold/frequency write
- threshold_we  out  1  one-cycle write strobe
- frequency_we  out  1  one-cycle write strobe
- tx_data  out  8  byte to transmit
- tx_write_en  out  1  one-cycle transmit strobe
- busy  out  1  high in any state but IDLE
- timeout_err  out  1  one-cycle pulse on timeout abort
- overrun  out  1  one-cycle pulse when a byte is dropped
- state_debug  out  4  current state encoding

## Operation
- Command byte: [7:4] opcode, [3:0] channel. If channel ≥ N_CH, reply NAK 0x15.
- 0x1 SET_THRESHOLD and 0x2 SET_FREQUENCY:
  - GET_ARG waits for one byte.
  - The matching _we strobe fires with param_data = that byte.
  - Reply is ACK 0x06.
- 0x3 READ_MAX:
  - WAIT_FFT waits for fft_data_ready. If it is already high on entry, capture happens in the first WAIT_FFT cycle.
  - Capture snapshots the selected channel's max_value, zero-extended to NB*8 bits.
  - Reply is NB bytes, MSB byte first.
- 0x4 ARM:
  - WAIT_TRIG waits for trigger high.
  - Reply is 0xA5.
- 0x5 PING: reply is 0x55.
- Any other opcode: reply NAK.
- States: IDLE, DECODE, GET_ARG, WAIT_FFT, WAIT_TRIG, WRITE, SEND, TX_GAP.
- Transitions:
  - IDLE→DECODE on rx_valid.
  - DECODE→GET_ARG, WAIT_FFT, WAIT_TRIG or SEND.
  - GET_ARG→WRITE on rx_valid.
  - WRITE→SEND.
  - WAIT_*→SEND on condition.
  - SEND→TX_GAP on write.
  - TX_GAP→SEND if bytes remain, else IDLE.
- Timeout:
  - Counter clears on entry to any wait state and counts `tick` pulses.
  - Reaching TIMEOUT_TICKS aborts to SEND with NAK and pulses timeout_err.
  - If the completion condition and the final tick coincide, the condition wins; no timeout.
- channel_sel updates only in DECODE for a valid channel. It holds otherwise.
- rx_valid in any state other than IDLE and GET_ARG drops the byte and pulses overrun the next cycle.
- Reset mid-operation: state returns to IDLE and every output takes its reset value. No partial reply resumes.

## Timing
- All outputs are registered.
- Reset values:
  - channel_sel 0, param_data 0, tx_data 0.
  - All strobes 0, busy 0, state_debug 0 (IDLE).
- Command latency: rx_valid at cycle t → DECODE at t+1 → SEND at t+2. tx_write_en is asserted at t+2 when tx_ready=1; otherwise SEND holds until tx_ready=1.
- tx_data is stable in the tx_write_en cycle.
- TX_GAP lasts one cycle. tx_ready is ignored during it, so the transmitter has a cycle to deassert.
- Argument latency: argument rx_valid at u → threshold_we/frequency_we at u+1 → first ACK attempt at u+2.
- READ_MAX: fft_data_ready seen at v → first reply byte attempt at v+1. Consecutive bytes are at least 2 cycles apart.

## Structure
- Shared package command_reader_pkg holds:
  - Opcode constants.
  - ACK/NAK/ARM/PING reply constants.
  - The state enum, 4-bit encoding matching state_debug.
- One sub-module, cmd_timeout_timer:
  - Tick counter of width $clog2(TIMEOUT_TICKS+1).
  - Ports: clear, tick, expired.
- Byte-count and shift register for reply serialisation stay in the top level.

## Test plan
- PING 0x50 with tx_ready=1 → tx_write_en at t+2, tx_data=0x55; busy returns to 0 at t+4.
- 0x12 then 0x7F → threshold_we pulse, param_data=0x7F, channel_sel=2, then ACK 0x06. Command 0x17 with N_CH=4 → NAK 0x15 and channel_sel unchanged.
- 0x31, fft_data_ready raised 5 cycles later, channel 1 max_value=10'h2C5 → bytes 0x02, 0xC5 in order. max_value changed after capture → reply unchanged.
- 0x40 with no trigger, TIMEOUT_TICKS=3, three tick pulses → NAK plus timeout_err pulse. Repeat with trigger raised on the third tick → 0xA5 and no timeout_err.
- rx_valid during WAIT_FFT → overrun pulse and state unchanged. Hold tx_ready=0 for 20 cycles in SEND → tx_write_en stays 0 until tx_ready rises.
- reset_b low for one cycle during GET_ARG → all outputs reset next cycle. A following PING is handled normally.
